// File: rtl/bram_reader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bram_reader_pkg
//  Description : Shared types and width helpers for the block-RAM stream
//                reader and its output skid buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
package bram_reader_pkg;

    // Controller state encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Output buffer holds exactly two words: enough to cover one in-flight
    // RAM read plus one word stalled at the stream interface.
    localparam int c_BUF_DEPTH = 2;

    // Occupancy counter must represent 0..c_BUF_DEPTH inclusive
    localparam int c_CNT_W = $clog2(c_BUF_DEPTH + 1);

    // RAM address width for a given depth (at least one bit)
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Word-count width: one extra bit so a full-depth count (== DEPTH) fits
    function automatic int len_width(input int depth);
        return addr_width(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stream_skid_buf.sv
`default_nettype none
// ============================================================================
//  Module      : stream_skid_buf
//  Description : Two-entry FIFO of {last, data} feeding a valid/ready
//                stream. Push and pop may occur in the same cycle. A flush
//                empties the buffer and takes priority over a push.
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_skid_buf
    import bram_reader_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_flush,
    input  logic               i_push,
    input  logic [WIDTH-1:0]   i_push_data,
    input  logic               i_push_last,
    input  logic               i_ready,
    output logic               o_valid,
    output logic [WIDTH-1:0]   o_data,
    output logic               o_last,
    output logic               o_pop,
    output logic [c_CNT_W-1:0] o_count
);

    logic [WIDTH-1:0]   r_data [c_BUF_DEPTH];
    logic               r_last [c_BUF_DEPTH];
    logic               r_wr_ptr;
    logic               r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic               w_pop;

    assign o_valid = (r_count != '0);
    assign w_pop   = o_valid & i_ready;
    assign o_pop   = w_pop;
    assign o_count = r_count;

    // The head entry is presented directly, so data and last stay stable
    // for as long as the consumer stalls.
    assign o_data  = r_data[r_rd_ptr];
    assign o_last  = r_last[r_rd_ptr] & o_valid;

    // Storage, pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_BUF_DEPTH; i++) begin
                r_data[i] <= '0;
                r_last[i] <= 1'b0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= '0;
        end else if (i_flush) begin
            for (int i = 0; i < c_BUF_DEPTH; i++) begin
                r_last[i] <= 1'b0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_data[r_wr_ptr] <= i_push_data;
                r_last[r_wr_ptr] <= i_push_last;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/bram_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module      : bram_stream_reader
//  Description : Read-side initiator for a single-port block RAM. On start,
//                fetches `length` consecutive words from `base_addr`
//                (wrapping modulo DEPTH) and emits them on a valid/ready
//                stream with a last flag. A two-entry skid buffer absorbs
//                the RAM's one-cycle read latency so the stream sustains one
//                word per cycle.
//  Options     : define BRAM_READER_ABORT_EN to add the `abort` input, which
//                cancels a running command and discards pending words.
//  Revision    : 1.0 - initial release
// ============================================================================
module bram_stream_reader
    import bram_reader_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2048,
    localparam int AW   = addr_width(DEPTH),
    localparam int LW   = len_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [AW-1:0]    base_addr,
    input  logic [LW-1:0]    length,
`ifdef BRAM_READER_ABORT_EN
    input  logic             abort,
`endif
    output logic             busy,
    output logic             done,
    output logic             mem_en,
    output logic             mem_we,
    output logic [AW-1:0]    mem_addr,
    input  logic [WIDTH-1:0] mem_dout,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last
);

    state_t             r_state;
    state_t             w_state_nxt;

    logic [AW-1:0]      r_addr;          // next address to issue
    logic [LW-1:0]      r_remain;        // words still to issue
    logic               r_inflight;      // a read was issued last cycle
    logic               r_inflight_last; // ... and it was the final word

    logic               w_abort;
    logic               w_pop;
    logic [c_CNT_W-1:0] w_count;
    logic [2:0]         w_occ;
    logic               w_room;
    logic               w_issue;
    logic               w_final_issue;
    logic               w_accept;
    logic [AW-1:0]      w_addr_inc;

`ifdef BRAM_READER_ABORT_EN
    assign w_abort = abort & ((r_state == ST_RUN) | (r_state == ST_DRAIN));
`else
    assign w_abort = 1'b0;
`endif

    // A command is latched only in IDLE; zero-length commands skip RUN
    assign w_accept = (r_state == ST_IDLE) & start & (length != '0);

    // Words committed to the buffer: already buffered plus the read whose
    // data arrives this cycle. A pop in this same cycle frees a slot, which
    // is what allows back-to-back issue at full rate.
    assign w_occ  = {1'b0, w_count} + {2'b00, r_inflight};
    assign w_room = (w_occ < 3'(c_BUF_DEPTH)) | w_pop;

    assign w_issue       = (r_state == ST_RUN) & ~w_abort & w_room;
    assign w_final_issue = w_issue & (r_remain == LW'(1));

    // Address increment with explicit wrap, correct for non-power-of-2 DEPTH
    assign w_addr_inc = (r_addr == AW'(DEPTH - 1)) ? '0 : r_addr + AW'(1);

    assign mem_en   = w_issue;
    assign mem_we   = 1'b0;
    assign mem_addr = r_addr;

    assign busy = (r_state == ST_RUN) | (r_state == ST_DRAIN);
    assign done = (r_state == ST_DONE);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = (length == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_abort) begin
                    w_state_nxt = ST_DONE;
                end else if (w_final_issue) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Finish once nothing is in flight and the buffer is empty
                // or is handing over its final word right now.
                if (w_abort) begin
                    w_state_nxt = ST_DONE;
                end else if (!r_inflight &&
                             ((w_count == '0) ||
                              ((w_count == c_CNT_W'(1)) && w_pop))) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Read address, remaining-word counter and in-flight tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr          <= '0;
            r_remain        <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr   <= base_addr;
                r_remain <= length;
            end else if (w_issue) begin
                r_addr   <= w_addr_inc;
                r_remain <= r_remain - LW'(1);
            end
            // The last flag travels with the read so it is fixed at issue
            r_inflight      <= w_issue;
            r_inflight_last <= w_final_issue;
        end
    end

    stream_skid_buf #(
        .WIDTH       (WIDTH)
    ) u_skid_buf (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (w_abort),
        .i_push      (r_inflight),
        .i_push_data (mem_dout),
        .i_push_last (r_inflight_last),
        .i_ready     (m_ready),
        .o_valid     (m_valid),
        .o_data      (m_data),
        .o_last      (m_last),
        .o_pop       (w_pop),
        .o_count     (w_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_bram_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bram_stream_reader
//  Description : Directed self-checking bench for bram_stream_reader with a
//                behavioural single-port RAM preloaded with RAM[i] = i.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_stream_reader;

    localparam int WIDTH = 8;
    localparam int DEPTH = 2048;
    localparam int AW    = 11;
    localparam int LW    = 12;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [AW-1:0]    base_addr;
    logic [LW-1:0]    length;
    logic             busy;
    logic             done;
    logic             mem_en;
    logic             mem_we;
    logic [AW-1:0]    mem_addr;
    logic [WIDTH-1:0] mem_dout;
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic             m_ready;
    logic             m_last;
`ifdef BRAM_READER_ABORT_EN
    logic             abort;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [WIDTH-1:0] ram [DEPTH];

    always #5 clk = ~clk;

    bram_stream_reader #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
`ifdef BRAM_READER_ABORT_EN
        .abort     (abort),
`endif
        .busy      (busy),
        .done      (done),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_dout  (mem_dout),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last)
    );

    // Behavioural RAM with one-cycle registered read
    always @(posedge clk) begin
        if (mem_en) mem_dout <= ram[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Stream / RAM-port monitor, sampled on the falling edge
    bit  mon_en = 1'b0;
    bit  we_bad = 1'b0;
    bit  stall_prev = 1'b0;
    int  prev_data;
    bit  prev_last;
    int  issued, popped;
    int  addr_q[$];
    int  data_q[$];
    bit  last_q[$];

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (mem_we !== 1'b0) we_bad = 1'b1;
            if (stall_prev) begin
                check("hold_valid", 32'(m_valid), 1);
                check("hold_data",  32'(m_data),  prev_data);
                check("hold_last",  32'(m_last),  32'(prev_last));
            end
            stall_prev = m_valid && !m_ready;
            prev_data  = int'(m_data);
            prev_last  = m_last;
            if (mem_en) begin
                addr_q.push_back(int'(mem_addr));
                issued++;
            end
            if (m_valid && m_ready) begin
                data_q.push_back(int'(m_data));
                last_q.push_back(m_last);
                popped++;
            end
            check("occupancy_le_2", 32'((issued - popped) <= 2), 1);
        end
    end

    function automatic bit rdy_pat(input int c);
        logic [15:0] p;
        p = 16'b0101_1100_1011_1001;   // bit0.. = 1,0,0,1,1,1,0,1,...
        return p[c % 16];
    endfunction

    task automatic clear_mon();
        addr_q.delete();
        data_q.delete();
        last_q.delete();
        issued     = 0;
        popped     = 0;
        stall_prev = 1'b0;
    endtask

    // Issue one command; returns the cycle (1 = cycle after the start edge)
    // in which done was seen, the first m_valid cycle, and busy in cycle 1.
    task automatic run_cmd(input int b, input int len, input bit use_pat,
                           output int done_cyc, output int fv_cyc, output int busy1);
        clear_mon();
        base_addr = AW'(b);
        length    = LW'(len);
        start     = 1'b1;
        m_ready   = use_pat ? rdy_pat(0) : 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        done_cyc = -1;
        fv_cyc   = -1;
        busy1    = -1;
        for (int c = 1; c <= 300; c++) begin
            m_ready = use_pat ? rdy_pat(c) : 1'b1;
            @(negedge clk);
            if (c == 1) busy1 = int'(busy);
            if (m_valid && fv_cyc < 0) fv_cyc = c;
            if (done) begin
                done_cyc = c;
                break;
            end
            @(posedge clk); #1;
        end
        check("done_seen", 32'(done_cyc > 0), 1);
        m_ready = 1'b1;
    endtask

    // Done must be a single-cycle pulse followed by an idle controller
    task automatic check_after_done(input string tag);
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, "_done_1cyc"}, 32'(done), 0);
        check({tag, "_busy_off"},  32'(busy), 0);
    endtask

    task automatic check_stream(input string tag, input int b, input int len);
        check({tag, "_beats"},  data_q.size(), len);
        check({tag, "_issues"}, addr_q.size(), len);
        for (int i = 0; i < len; i++) begin
            if (i < data_q.size()) begin
                check({tag, "_data"}, data_q[i], (b + i) % 256 == 0 ? 0 : ((b + i) % DEPTH) % 256);
                check({tag, "_last"}, 32'(last_q[i]), 32'(i == len - 1));
            end
            if (i < addr_q.size()) begin
                check({tag, "_addr"}, addr_q[i], (b + i) % DEPTH);
            end
        end
    endtask

    int dc, fv, b1, nb;

    initial begin
        for (int i = 0; i < DEPTH; i++) ram[i] = 8'(i);
        rst       = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        length    = '0;
        m_ready   = 1'b0;
`ifdef BRAM_READER_ABORT_EN
        abort     = 1'b0;
`endif

        // ---- reset state ----
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy",     32'(busy),     0);
        check("rst_done",     32'(done),     0);
        check("rst_mem_en",   32'(mem_en),   0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_m_valid",  32'(m_valid),  0);
        check("rst_m_last",   32'(m_last),   0);
        check("rst_m_data",   32'(m_data),   0);
        @(posedge clk); #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        // ---- base 5, length 4, no backpressure ----
        run_cmd(5, 4, 1'b0, dc, fv, b1);
        check("t1_done_cycle",  dc, 7);
        check("t1_first_valid", fv, 3);
        check("t1_busy",        b1, 1);
        check_stream("t1", 5, 4);
        check_after_done("t1");

        // ---- address wrap at top of RAM ----
        run_cmd(2046, 4, 1'b0, dc, fv, b1);
        check("t2_done_cycle", dc, 7);
        check_stream("t2", 2046, 4);
        check_after_done("t2");

        // ---- length 10 with toggling backpressure ----
        run_cmd(100, 10, 1'b1, dc, fv, b1);
        check_stream("t3", 100, 10);
        check_after_done("t3");

        // ---- zero-length command ----
        run_cmd(0, 0, 1'b0, dc, fv, b1);
        check("t4_done_cycle", dc, 1);
        check("t4_no_valid",   fv, -1);
        check("t4_busy",       b1, 0);
        check_stream("t4", 0, 0);
        check_after_done("t4");

        // ---- reset in the middle of a run ----
        clear_mon();
        base_addr = '0;
        length    = LW'(20);
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        nb    = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (m_valid && m_ready) nb++;
            if (nb == 3) break;
            @(posedge clk); #1;
        end
        check("t5_three_beats", nb, 3);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("t5_busy",     32'(busy),     0);
        check("t5_done",     32'(done),     0);
        check("t5_mem_en",   32'(mem_en),   0);
        check("t5_mem_addr", 32'(mem_addr), 0);
        check("t5_m_valid",  32'(m_valid),  0);
        check("t5_m_last",   32'(m_last),   0);
        check("t5_m_data",   32'(m_data),   0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("t5_no_done", 32'(done), 0);
            @(posedge clk); #1;
        end
        run_cmd(10, 3, 1'b0, dc, fv, b1);
        check("t5_restart_done_cycle", dc, 6);
        check_stream("t5r", 10, 3);
        check_after_done("t5r");

`ifdef BRAM_READER_ABORT_EN
        // ---- abort on the second beat of an 8-word command ----
        clear_mon();
        base_addr = AW'(40);
        length    = LW'(8);
        m_ready   = 1'b1;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        nb    = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (m_valid && m_ready) nb++;
            if (nb == 2) begin
                abort = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check("t6_second_beat", nb, 2);
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("t6_valid_drop", 32'(m_valid), 0);
        check("t6_done",       32'(done),    1);
        check("t6_last",       32'(m_last),  0);
        check_after_done("t6");
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("t6_quiet_valid", 32'(m_valid), 0);
            check("t6_quiet_done",  32'(done),    0);
            @(posedge clk); #1;
        end
        check("t6_beats", data_q.size(), 2);
        nb = 0;
        foreach (last_q[i]) if (last_q[i]) nb++;
        check("t6_no_last", nb, 0);
        if (data_q.size() >= 2) begin
            check("t6_data0", data_q[0], 40);
            check("t6_data1", data_q[1], 41);
        end
        run_cmd(7, 2, 1'b0, dc, fv, b1);
        check("t6_restart_done_cycle", dc, 5);
        check_stream("t6r", 7, 2);
`endif

        check("mem_we_never", 32'(we_bad), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
